qos_classifier: RTL
===================

// Module: qos_classifier
// PURPOSE
//  Ingress side of the QoS path: accepts one DATA_BITS word per cycle from the source and writes
//  it into one of QUEUE_QUANTITY class FIFOs. The FIFO is selected by the class field (top
//  log2(QUEUE_QUANTITY) bits of the word). The qos arbiter drains those FIFOs on the read side.
//  A one-word holding stage absorbs FIFO-full. On full, the block either back-pressures or drops
//  the word, counting the drop per queue.
// PARAMETERS
//  QUEUE_QUANTITY  4  number of class FIFOs (power of 2, >=2)
//  DATA_BITS       8  word width; class = data[DATA_BITS-1 -: $clog2(QUEUE_QUANTITY)]
//  DROP_ON_FULL    0  0: stall (back-pressure) on full target; 1: discard word, count drop
//  CNT_BITS        8  width of each per-queue drop counter (saturating)
// PORTS
//  clk        in   1                     system clock, all state on posedge
//  rst        in   1                     synchronous reset, active high
//  enb        in   1                     block enable; 0 freezes all state
//  in_valid   in   1                     source word valid
//  in_data    in   DATA_BITS             source word
//  in_ready   out  1                     word accepted at posedge when in_valid&&in_ready
//  fifo_full  in   QUEUE_QUANTITY        per-FIFO full flag (bit q = FIFO q)
//  fifo_wr_en out  QUEUE_QUANTITY        one-hot push strobe, bit q pushes FIFO q
//  fifo_data  out  DATA_BITS             data to all FIFOs; valid where a fifo_wr_en bit is 1
//  drop_cnt   out  QUEUE_QUANTITY*CNT_BITS  drops per queue; queue q at [q*CNT_BITS +: CNT_BITS]
//  drop_err   out  1                     sticky: at least one word dropped since reset
// BEHAVIOUR
//  Reset (rst=1 at posedge, overrides enb): state=IDLE, holding register cleared, held word
//   discarded, drop_cnt=0, drop_err=0. While rst=1: in_ready=0, fifo_wr_en=0, fifo_data=0.
//  Holding stage: hold_valid, hold_data, hold_q; fifo_data = hold_data (0 when !hold_valid).
//  FSM: IDLE (hold empty) / LOADED (hold full). Let tgt_full = fifo_full[hold_q].
//   IDLE  : in_ready=enb. Accept -> load hold, capture class -> LOADED.
//   LOADED, !tgt_full: fifo_wr_en[hold_q]=enb (combinational). FIFO samples the word at this
//           posedge. Same edge: a new word may be accepted (stay LOADED); else -> IDLE.
//   LOADED, tgt_full, DROP_ON_FULL=0: fifo_wr_en=0, in_ready=0. Hold the word unchanged
//           (no loss, no reorder) until tgt_full falls.
//   LOADED, tgt_full, DROP_ON_FULL=1: fifo_wr_en=0. At this posedge, discard the held word,
//           saturating-increment drop_cnt[hold_q] and set drop_err. in_ready=enb, so a new
//           word can load the same edge.
//  in_ready = enb && !rst && (!hold_valid || !tgt_full || DROP_ON_FULL). This is combinational
//   from fifo_full; document it as a timing path.
//  Latency: word accepted at edge N is pushed at edge N+1 if its FIFO is not full.
//   Throughput: 1 word/cycle. Order is preserved across all queues.
//  Only one fifo_wr_en bit is ever 1. fifo_full of non-target queues is ignored.
//   A full queue q stalls traffic for other queues in stall mode (head-of-line by design).
//  enb=0: in_ready=0, fifo_wr_en=0, no counter or FSM change. The held word is kept and
//   resumes on enb=1.
//  Drop counter at 2^CNT_BITS-1 stays there. drop_err clears only on rst.
//  in_valid while in_ready=0 is not accepted. The source holds in_data stable until accepted.
// TESTING
//  1 reset: rst=1 for 4 clks with in_valid=1 -> in_ready=0, fifo_wr_en=0, drop_cnt=0, drop_err=0.
//  2 routing: push 8'h05,8'h45,8'h85,8'hC5 back-to-back, fifo_full=0 ->
//    fifo_wr_en=0001,0010,0100,1000 on consecutive cycles, 1-cycle latency, fifo_data matches.
//  3 stall (DROP_ON_FULL=0): fifo_full=4'b0100, send 8'h9A then 8'h11 -> 8'h9A held, in_ready=0.
//    Clear full after 5 clks -> 8'h9A pushed to q2, then 8'h11 to q0, drop_cnt all 0.
//  4 drop (DROP_ON_FULL=1): fifo_full=4'b1000, send 3x 8'hF0 -> no wr_en, drop_cnt[q3]=3,
//    drop_err=1, in_ready stays 1. Words to q0 are still pushed.
//  5 enb/reset mid-op: held word for a full queue; enb=0 3 clks -> frozen. rst=1 ->
//    hold cleared, no push of the held word after full clears.
//  6 saturation (CNT_BITS=2, drop mode): 6 drops to q1 -> drop_cnt[q1]=3, other counters 0.

Source files
------------

// File: rtl/qos_classifier.sv
// Ingress classifier for the QoS path: one-word holding stage that steers each word into the
// class FIFO named by its top bits, stalling or dropping (with per-queue counters) on FIFO-full.
module qos_classifier #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int DATA_BITS      = 8,
    parameter int DROP_ON_FULL   = 0,
    parameter int CNT_BITS       = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enb,
    input  logic                               in_valid,
    input  logic [DATA_BITS-1:0]               in_data,
    output logic                               in_ready,
    input  logic [QUEUE_QUANTITY-1:0]          fifo_full,
    output logic [QUEUE_QUANTITY-1:0]          fifo_wr_en,
    output logic [DATA_BITS-1:0]               fifo_data,
    output logic [QUEUE_QUANTITY*CNT_BITS-1:0] drop_cnt,
    output logic                               drop_err
);

    localparam int CLS_BITS = $clog2(QUEUE_QUANTITY);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOADED = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_BITS-1:0]  hold_data_q, hold_data_d;
    logic [CLS_BITS-1:0]   hold_cls_q, hold_cls_d;
    logic [CNT_BITS-1:0]   cnt_q [QUEUE_QUANTITY];
    logic [CNT_BITS-1:0]   cnt_d [QUEUE_QUANTITY];
    logic                  drop_err_q, drop_err_d;

    logic                  active_s;
    logic                  tgt_full_s;
    logic                  push_s;
    logic                  drop_s;
    logic                  accept_s;

    // Next-state, push/drop decision and handshake outputs.
    // in_ready and fifo_wr_en depend combinationally on fifo_full: a timing path from the
    // FIFO full flags through the class mux to both the source and the FIFO push strobes.
    always_comb begin
        active_s    = enb && !rst;
        tgt_full_s  = fifo_full[hold_cls_q];
        push_s      = 1'b0;
        drop_s      = 1'b0;
        in_ready    = 1'b0;
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_cls_d  = hold_cls_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                in_ready = active_s;
            end
            LOADED: begin
                if (!tgt_full_s) begin
                    push_s   = active_s;
                    in_ready = active_s;
                end else if (DROP_ON_FULL != 0) begin
                    drop_s   = active_s;
                    in_ready = active_s;
                end else begin
                    in_ready = 1'b0;
                end
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase

        accept_s = in_valid && in_ready;

        if (accept_s) begin
            state_d     = LOADED;
            hold_data_d = in_data;
            hold_cls_d  = in_data[DATA_BITS-1 -: CLS_BITS];
        end else if (push_s || drop_s) begin
            state_d     = IDLE;
            hold_data_d = '0;
        end else begin
            state_d     = state_q;
        end

        for (int q = 0; q < QUEUE_QUANTITY; q++) begin
            if (drop_s && (hold_cls_q == CLS_BITS'(q)) && (cnt_q[q] != {CNT_BITS{1'b1}})) begin
                cnt_d[q] = cnt_q[q] + CNT_BITS'(1);
            end else begin
                cnt_d[q] = cnt_q[q];
            end
        end

        drop_err_d = drop_err_q || drop_s;

        if (push_s) begin
            fifo_wr_en = {{(QUEUE_QUANTITY-1){1'b0}}, 1'b1} << hold_cls_q;
        end else begin
            fifo_wr_en = '0;
        end

        if ((state_q == LOADED) && !rst) begin
            fifo_data = hold_data_q;
        end else begin
            fifo_data = '0;
        end
    end

    // Flatten per-queue drop counters onto the output bus.
    always_comb begin
        for (int q = 0; q < QUEUE_QUANTITY; q++) begin
            drop_cnt[q*CNT_BITS +: CNT_BITS] = cnt_q[q];
        end
        drop_err = drop_err_q;
    end

    // State, holding stage and drop statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_data_q <= '0;
            hold_cls_q  <= '0;
            drop_err_q  <= 1'b0;
            for (int q = 0; q < QUEUE_QUANTITY; q++) begin
                cnt_q[q] <= '0;
            end
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_cls_q  <= hold_cls_d;
            drop_err_q  <= drop_err_d;
            for (int q = 0; q < QUEUE_QUANTITY; q++) begin
                cnt_q[q] <= cnt_d[q];
            end
        end
    end

endmodule
